// File: rtl/booth_mult_arbiter.sv
// Round-robin shared sequential radix-2 Booth multiplier.
// Grants one requester at a time, retires one multiplier bit per cycle, returns a tagged 2N-bit product.
module booth_mult_arbiter #(
  parameter int N       = 32,
  parameter int NUM_REQ = 4,
  localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*N-1:0] req_a,
  input  logic [NUM_REQ*N-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IW-1:0]        rsp_id,
  output logic [2*N-1:0]       rsp_product
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [IW-1:0]         last_grant;
  logic [IW-1:0]         op_id;
  logic [CW-1:0]         cnt;
  logic signed [N:0]     acc;
  logic signed [N:0]     mcand;
  logic [N-1:0]          mplr;
  logic                  qm1;

  logic                  gnt_found;
  logic [IW-1:0]         gnt_idx;
  logic [IW-1:0]         cand;
  logic [N-1:0]          sel_a;
  logic [N-1:0]          sel_b;
  logic [2*N+1:0]        step;

  // One Booth step: add/subtract the sign-extended multiplicand, then
  // arithmetic-shift {A,Q,Q(-1)} right. Result packs {A', Q', Q(-1)'}.
  function automatic logic [2*N+1:0] booth_step(
    input logic signed [N:0] a,
    input logic signed [N:0] m,
    input logic [N-1:0]      q,
    input logic              qm
  );
    logic signed [N:0] s;
    case ({q[0], qm})
      2'b10:   s = a - m;
      2'b01:   s = a + m;
      default: s = a;
    endcase
    return {s[N], s, q};
  endfunction

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign sel_a = req_a[int'(gnt_idx)*N +: N];
  assign sel_b = req_b[int'(gnt_idx)*N +: N];
  assign step  = booth_step(acc, mcand, mplr, qm1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      cnt         <= '0;
      last_grant  <= IW'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            mcand      <= {sel_a[N-1], sel_a};
            mplr       <= sel_b;
            acc        <= '0;
            qm1        <= 1'b0;
            cnt        <= '0;
            op_id      <= gnt_idx;
            last_grant <= gnt_idx;
            state      <= RUN;
          end
        end
        RUN: begin
          acc  <= step[2*N+1:N+1];
          mplr <= step[N:1];
          qm1  <= step[0];
          cnt  <= cnt + CW'(1);
          // Last step: low 2N bits of {A,Q} are the exact product.
          if (cnt == CW'(N - 1)) begin
            state       <= DONE;
            rsp_valid   <= 1'b1;
            rsp_product <= step[2*N:1];
            rsp_id      <= op_id;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Scoreboard bench for booth_mult_arbiter: directed checks at N=8/NUM_REQ=4,
// randomized traffic at N=32/NUM_REQ=3 against a transaction-level reference model.
module tb_booth_mult_arbiter;

  typedef struct {
    int     id;
    longint prod;
  } exp_t;

  logic        clk;
  logic        rst;

  logic [3:0]  v8, rdy8;
  logic [31:0] a8, b8;
  logic        rspv8, rspr8;
  logic [1:0]  id8;
  logic [15:0] p8;

  logic [2:0]  v32, rdy32;
  logic [95:0] a32, b32;
  logic        rspv32, rspr32;
  logic [1:0]  id32;
  logic [63:0] p32;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  exp_t q8[$];
  exp_t q32[$];
  int   glog8[$];
  int   gcyc8[$];
  bit   busy8, busy32, held8, held32;
  int   k8, k32, lg8, lg32;
  int   nacc8[4]  = '{default: 0};
  int   nacc32[3] = '{default: 0};
  logic [1:0]  hid8, hid32;
  logic [15:0] hp8;
  logic [63:0] hp32;
  int          lastid8;
  logic [15:0] lastp8;

  booth_mult_arbiter #(.N(8), .NUM_REQ(4)) dut8 (
    .clk(clk), .rst(rst), .req_valid(v8), .req_ready(rdy8), .req_a(a8), .req_b(b8),
    .rsp_valid(rspv8), .rsp_ready(rspr8), .rsp_id(id8), .rsp_product(p8)
  );

  booth_mult_arbiter #(.N(32), .NUM_REQ(3)) dut32 (
    .clk(clk), .rst(rst), .req_valid(v32), .req_ready(rdy32), .req_a(a32), .req_b(b32),
    .rsp_valid(rspv32), .rsp_ready(rspr32), .rsp_id(id32), .rsp_product(p32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Round-robin rule: first valid requester after the last grant, wrapping.
  function automatic int rr_pick(input logic [15:0] v, input int lg, input int nr);
    for (int k = 1; k <= nr; k++) begin
      int i;
      i = (lg + k) % nr;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Reference model for the 8-bit instance: engine busy from accept until the
  // response handshake; response due N+1 cycles after the accept cycle.
  always @(negedge clk) begin : mon8
    int   pk;
    exp_t e;
    if (rst) begin
      chk("rst_rdy8", 64'(rdy8), 64'(0));
      busy8 = 0; k8 = 0; lg8 = 3; held8 = 0;
      q8.delete();
    end else begin
      if (busy8) k8++;
      chk("vld8", 64'(rspv8), 64'(busy8 && k8 >= 9));
      pk = busy8 ? -1 : rr_pick(16'(v8), lg8, 4);
      chk("rdy8", 64'(rdy8), (pk >= 0) ? (64'(1) << pk) : 64'(0));
      if (held8) begin
        chk("hold_id8", 64'(id8), 64'(hid8));
        chk("hold_p8", 64'(p8), 64'(hp8));
      end
      held8 = rspv8 && !rspr8; hid8 = id8; hp8 = p8;
      if (pk >= 0) begin
        busy8 = 1; k8 = 0; lg8 = pk; nacc8[pk]++;
        glog8.push_back(pk); gcyc8.push_back(cyc);
        e.id   = pk;
        e.prod = longint'($signed(a8[pk*8 +: 8])) * longint'($signed(b8[pk*8 +: 8]));
        q8.push_back(e);
      end
      if (rspv8 && rspr8) begin
        chk("rsp8_expected", 64'(q8.size() != 0), 64'(1));
        if (q8.size() != 0) begin
          e = q8.pop_front();
          chk("id8", 64'(id8), 64'(e.id));
          chk("prod8", 64'(p8), 64'(e.prod) & 64'hFFFF);
          lastid8 = int'(id8); lastp8 = p8;
        end
        busy8 = 0;
      end
    end
  end

  always @(negedge clk) begin : mon32
    int   pk;
    exp_t e;
    if (rst) begin
      chk("rst_rdy32", 64'(rdy32), 64'(0));
      busy32 = 0; k32 = 0; lg32 = 2; held32 = 0;
      q32.delete();
    end else begin
      if (busy32) k32++;
      chk("vld32", 64'(rspv32), 64'(busy32 && k32 >= 33));
      pk = busy32 ? -1 : rr_pick(16'(v32), lg32, 3);
      chk("rdy32", 64'(rdy32), (pk >= 0) ? (64'(1) << pk) : 64'(0));
      if (held32) begin
        chk("hold_id32", 64'(id32), 64'(hid32));
        chk("hold_p32", p32, hp32);
      end
      held32 = rspv32 && !rspr32; hid32 = id32; hp32 = p32;
      if (pk >= 0) begin
        busy32 = 1; k32 = 0; lg32 = pk; nacc32[pk]++;
        e.id   = pk;
        e.prod = longint'($signed(a32[pk*32 +: 32])) * longint'($signed(b32[pk*32 +: 32]));
        q32.push_back(e);
      end
      if (rspv32 && rspr32) begin
        chk("rsp32_expected", 64'(q32.size() != 0), 64'(1));
        if (q32.size() != 0) begin
          e = q32.pop_front();
          chk("id32", 64'(id32), 64'(e.id));
          chk("prod32", p32, 64'(e.prod));
        end
        busy32 = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc8(input int r, input int start);
    int t;
    t = 0;
    while (nacc8[r] == start && t < 60) begin
      tick();
      t++;
    end
    chk("accept8_seen", 64'(nacc8[r] != start), 64'(1));
  endtask

  task automatic drain8();
    int t;
    t = 0;
    while ((busy8 || q8.size() != 0) && t < 200) begin
      tick();
      t++;
    end
    chk("drain8", 64'(busy8 || q8.size() != 0), 64'(0));
  endtask

  task automatic issue8(input int r, input logic [7:0] a, input logic [7:0] b);
    int s;
    a8[r*8 +: 8] = a;
    b8[r*8 +: 8] = b;
    s = nacc8[r];
    v8[r] = 1'b1;
    wait_acc8(r, s);
    v8[r] = 1'b0;
    a8 = $urandom;
    b8 = $urandom;
    drain8();
  endtask

  initial begin
    int s, t, total;
    int seen32[3];
    rst = 1'b1;
    v8 = '0; a8 = '0; b8 = '0; rspr8 = 1'b1;
    v32 = '0; a32 = '0; b32 = '0; rspr32 = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_vld8", 64'(rspv8), 64'(0));
    chk("reset_id8", 64'(id8), 64'(0));
    chk("reset_p8", 64'(p8), 64'(0));
    chk("reset_vld32", 64'(rspv32), 64'(0));
    chk("reset_p32", p32, 64'(0));

    issue8(1, 8'd7, 8'hFD);
    chk("basic_id", 64'(lastid8), 64'(1));
    chk("basic_prod", 64'(lastp8), 64'h0000_FFEB);

    issue8(0, 8'h80, 8'h80);
    chk("ext_min_min", 64'(lastp8), 64'h4000);
    issue8(1, 8'h80, 8'h7F);
    chk("ext_min_max", 64'(lastp8), 64'hC080);
    issue8(2, 8'h7F, 8'h80);
    chk("ext_max_min", 64'(lastp8), 64'hC080);
    issue8(3, 8'h00, 8'hFF);
    chk("ext_zero", 64'(lastp8), 64'h0000);

    // Round-robin from a fresh reset with every requester held valid.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    glog8.delete(); gcyc8.delete();
    a8 = $urandom; b8 = $urandom;
    v8 = 4'hF;
    t = 0;
    while (glog8.size() < 5 && t < 100) begin
      tick();
      t++;
    end
    v8 = '0;
    drain8();
    chk("rr_count", 64'(glog8.size() >= 5), 64'(1));
    if (glog8.size() >= 5) begin
      chk("rr_g0", 64'(glog8[0]), 64'(0));
      chk("rr_g1", 64'(glog8[1]), 64'(1));
      chk("rr_g2", 64'(glog8[2]), 64'(2));
      chk("rr_g3", 64'(glog8[3]), 64'(3));
      chk("rr_g4", 64'(glog8[4]), 64'(0));
      for (int i = 0; i < 4; i++) chk("rr_spacing", 64'(gcyc8[i+1] - gcyc8[i]), 64'(10));
    end

    // Backpressure: five DONE cycles with rsp_ready low, another requester waiting.
    rspr8 = 1'b0;
    a8[24 +: 8] = 8'd100; b8[24 +: 8] = 8'd3;
    s = nacc8[3];
    v8[3] = 1'b1;
    wait_acc8(3, s);
    v8[3] = 1'b0;
    a8[0 +: 8] = 8'hF7; b8[0 +: 8] = 8'd11;
    s = nacc8[0];
    v8[0] = 1'b1;
    t = 0;
    while (!rspv8 && t < 40) begin
      tick();
      t++;
    end
    chk("bp_reach_done", 64'(rspv8), 64'(1));
    repeat (4) begin
      tick();
      chk("bp_vld", 64'(rspv8), 64'(1));
      chk("bp_no_ready", 64'(rdy8), 64'(0));
    end
    rspr8 = 1'b1;
    tick();
    chk("bp_idle_grant", 64'(rdy8), 64'(1));
    chk("bp_id", 64'(lastid8), 64'(3));
    chk("bp_prod", 64'(lastp8), 64'h012C);
    wait_acc8(0, s);
    v8[0] = 1'b0;
    drain8();
    chk("bp_next_prod", 64'(lastp8), 64'hFF9D);

    // Reset during RUN step 3 discards the op; requester 2 stays valid.
    a8[16 +: 8] = 8'hFB; b8[16 +: 8] = 8'd9;
    s = nacc8[2];
    v8[2] = 1'b1;
    wait_acc8(2, s);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_vld", 64'(rspv8), 64'(0));
    s = nacc8[2];
    wait_acc8(2, s);
    v8[2] = 1'b0;
    drain8();
    chk("midrst_id", 64'(lastid8), 64'(2));
    chk("midrst_prod", 64'(lastp8), 64'hFFD3);

    // Randomized traffic on the 32-bit, 3-requester instance.
    for (int i = 0; i < 3; i++) seen32[i] = nacc32[i];
    total = 0;
    t = 0;
    while (total < 1000 && t < 90000) begin
      tick();
      t++;
      rspr32 = 1'($urandom_range(0, 1));
      for (int i = 0; i < 3; i++) begin
        if (nacc32[i] != seen32[i]) begin
          seen32[i] = nacc32[i];
          total++;
          v32[i] = 1'($urandom_range(0, 1));
          a32[i*32 +: 32] = rnd32();
          b32[i*32 +: 32] = rnd32();
        end else if (!v32[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            v32[i] = 1'b1;
            a32[i*32 +: 32] = rnd32();
            b32[i*32 +: 32] = rnd32();
          end
        end else begin
          case ($urandom_range(0, 31))
            0:       v32[i] = 1'b0;
            1, 2:    a32[i*32 +: 32] = rnd32();
            default: ;
          endcase
        end
      end
    end
    chk("rand_total", 64'(total >= 1000), 64'(1));
    v32 = '0;
    rspr32 = 1'b1;
    t = 0;
    while ((busy32 || q32.size() != 0) && t < 200) begin
      tick();
      t++;
    end
    chk("drain32", 64'(busy32 || q32.size() != 0), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
- Shares one sequential radix-2 Booth multiply engine among NUM_REQ requesters.
- A round-robin arbiter grants one request at a time; the engine retires one multiplier bit per cycle.
- A single response port returns the signed 2N-bit product tagged with the requester ID.
- Sits between several client blocks and the multiplier datapath, replacing per-client combinational Booth arrays.

Parameters:
- N, 32, operand width in bits (signed, two's complement); N >= 4.
- NUM_REQ, 4, number of requesters; 2 to 16. ID width IW = clog2(NUM_REQ), with a minimum of 1.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept strobe; at most one bit high per cycle.
- req_a  input  NUM_REQ*N  packed multiplicands; slice i is bits [i*N +: N].
- req_b  input  NUM_REQ*N  packed multipliers (Booth-scanned operand); slice i is bits [i*N +: N].
- rsp_valid  output  1  product valid.
- rsp_ready  input  1  consumer accepts the product.
- rsp_id  output  IW  index of the requester that owns the product.
- rsp_product  output  2N  signed product a*b.

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_product=0; bit counter=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has highest priority first.
  - rst overrides every other input on the same edge.
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready is combinational from req_valid and last_grant, asserted only while state=IDLE and rst=0.
  - Grant g = first i with req_valid[i]=1, searching last_grant+1, +2, ... with wrap-around modulo NUM_REQ.
  - On that edge: latch req_a[g] and req_b[g]; record the ID; set last_grant=g; clear accumulator, Q(-1) and counter; go to RUN.
  - A transfer completes only when req_valid[g] and req_ready[g] are both 1.
  - No request pending: stay in IDLE.
- RUN: one Booth step per cycle for N cycles, counter 0..N-1.
  - Examine pair {b[counter], Q(-1)}:
    - 10: A = A - M.
    - 01: A = A + M.
    - 00 or 11: no change.
  - Then shift {A,Q} arithmetic-right by 1 and update Q(-1).
  - A is N+1 bits with M sign-extended, so M = -2^(N-1) never overflows. No post-correction step is allowed.
  - After step N-1: go to DONE and load rsp_product with the low 2N bits of the result.
- DONE:
  - rsp_valid=1; rsp_id and rsp_product stay stable until the rsp_valid && rsp_ready edge, then go to IDLE.
  - rsp_product and rsp_id hold their last values after the handshake; only rsp_valid drops.
  - No new grant is issued while in RUN or DONE. Pending requests simply wait; req_ready stays 0.
- Latency: accept edge at cycle T gives rsp_valid=1 from cycle T+N+1.
  - Minimum initiation interval is N+2 cycles: one IDLE cycle after each response.
- Operand sampling: operands are sampled only on the accept edge. Later changes to req_a/req_b, or req_valid dropping, do not affect the operation in flight.
- req_valid dropping before grant: no accept occurs and no state change results.
- Reset mid-operation (RUN or DONE): the operation is discarded with no response; all state returns to reset values on that edge.
- Products are exact signed two's complement for the full input range, including -2^(N-1) * -2^(N-1) = +2^(2N-2).

Test Plan (N=8, NUM_REQ=4 unless noted):
- Basic: requester 1 sends a=7, b=-3 -> req_ready[1] pulses once; rsp_valid rises 9 cycles after the accept; rsp_id=1; rsp_product=16'hFFEB (-21).
- Extremes: a=-128, b=-128 -> 16'h4000. a=-128, b=127 -> 16'hC080. a=127, b=-128 -> 16'hC080. a=0, b=-1 -> 16'h0000.
- Round-robin: all four requesters valid continuously after reset with rsp_ready=1 -> grant order 0,1,2,3,0. Each grant is 10 cycles apart; no two req_ready bits are ever high together.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid stays 1; product and ID are stable; no req_ready is asserted. Accept on the 6th cycle -> IDLE the next cycle.
- Reset mid-op: assert rst during RUN step 3 -> rsp_valid stays 0 and state is IDLE. The still-valid requester 2 is re-granted afterwards and its product is correct.
- Random: 1000 random operand pairs at N=32, NUM_REQ=3, random rsp_ready -> every product equals the signed reference product; ID and ordering match round-robin.
